// File: rtl/mul_shift_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_shift_add_pkg
// Purpose  : Shared state encoding and widths for the shift-and-add multiplier
// Revision : 1.0 - initial release
// ============================================================================
package mul_shift_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int N_DEFAULT     = 16;
   localparam int PROD_W        = 2 * N_DEFAULT;
   localparam int SUM_W         = N_DEFAULT + 1;
   localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT);

   // A one-bit operand still needs a one-bit counter
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mul_shift_add
// Purpose  : Sequential unsigned shift-and-add multiplier, 2N+2 cycles/product
// Revision : 1.0 - initial release
// ============================================================================
module mul_shift_add
   import mul_shift_add_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           St,
   input  logic [N-1:0]   Multiplicando,
   input  logic [N-1:0]   Multiplicador,
   output logic [2*N-1:0] Produto,
   output logic           Busy,
   output logic           Done
);

   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);

   state_t           r_state;
   logic [N-1:0]     r_m;
   logic [2*N:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [2*N-1:0]   r_produto;

   logic [N:0]       w_sum;
   logic [2*N:0]     w_shifted;

   // Upper half is at most 2^N-1 before the add, so N+1 bits hold the carry
   assign w_sum     = r_acc[2*N:N] + {1'b0, r_m};
   assign w_shifted = {1'b0, r_acc[2*N:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_m       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_produto <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (St) begin
                  r_m     <= Multiplicando;
                  r_acc   <= {{(N+1){1'b0}}, Multiplicador};
                  r_cnt   <= '0;
                  r_state <= ADD;
               end
            end
            ADD: begin
               if (r_acc[0]) begin
                  r_acc[2*N:N] <= w_sum;
               end
               r_state <= SHIFT;
            end
            SHIFT: begin
               r_acc <= w_shifted;
               if (r_cnt == C_CNT_LAST) begin
                  r_produto <= w_shifted[2*N-1:0];
                  r_state   <= DONE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= ADD;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign Produto = r_produto;
   assign Busy    = (r_state != IDLE);
   assign Done    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_shift_add
// Purpose  : Directed self-checking bench for mul_shift_add (N=16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_shift_add;

   localparam int N = 16;

   logic           clk;
   logic           rst;
   logic           St;
   logic [N-1:0]   Multiplicando;
   logic [N-1:0]   Multiplicador;
   logic [2*N-1:0] Produto;
   logic           Busy;
   logic           Done;

   int n_checks = 0;
   int n_errors = 0;

   mul_shift_add #(.N(N)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .St            (St),
      .Multiplicando (Multiplicando),
      .Multiplicador (Multiplicador),
      .Produto       (Produto),
      .Busy          (Busy),
      .Done          (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse St for one cycle; on return the bench is in cycle 1
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      Multiplicando = a;
      Multiplicador = b;
      St = 1'b1;
      tick();
      St = 1'b0;
   endtask

   // From cycle 1, advance until Done (bounded); returns the cycle Done was seen
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!Done && cyc < 45) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp);
      int cyc;
      start_op(a, b);
      check_val({tag, "_busy_c1"}, Busy, 1);
      wait_done(cyc);
      check_val({tag, "_done_cycle"}, cyc, 33);
      check_val({tag, "_prod"}, Produto, exp);
      tick();
      check_val({tag, "_idle_done"}, Done, 0);
   endtask

   initial begin
      int cyc;
      int n_done;
      int t0;
      rst = 1'b1;
      St = 1'b0;
      Multiplicando = '0;
      Multiplicador = '0;
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         check_val("idle_prod", Produto, 0);
         check_val("idle_busy", Busy, 0);
         check_val("idle_done", Done, 0);
         tick();
      end

      // 5*3 with explicit latency and hold checks
      start_op(16'd5, 16'd3);
      check_val("c1_busy", Busy, 1);
      wait_done(cyc);
      check_val("c1_done_cycle", cyc, 33);
      check_val("c1_prod", Produto, 32'h0000000F);
      tick();
      check_val("c1_done_pulse", Done, 0);
      check_val("c1_busy_idle", Busy, 0);
      tick();
      tick();
      check_val("c1_prod_hold", Produto, 32'h0000000F);

      run_mul("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run_mul("zero", 16'h1234, 16'h0000, 32'h00000000);

      // 7*9 with stray St pulses in cycles 5 and 20
      Multiplicando = 16'd7;
      Multiplicador = 16'd9;
      St = 1'b1;
      tick();
      n_done = 0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 5 || c == 20) begin
            St = 1'b1;
            Multiplicando = 16'd2;
            Multiplicador = 16'd2;
         end else begin
            St = 1'b0;
         end
         if (Done) n_done++;
         tick();
      end
      check_val("ign_done_count", n_done, 1);
      check_val("ign_prod", Produto, 32'd63);

      // Abort 100*100 with reset in cycle 12
      start_op(16'd100, 16'd100);
      for (int c = 1; c < 12; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_busy", Busy, 0);
      check_val("rst_prod", Produto, 0);
      check_val("rst_done", Done, 0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (Done) n_done++;
         tick();
      end
      check_val("rst_no_done", n_done, 0);

      run_mul("post_rst", 16'd4, 16'd4, 32'd16);

      // St held high: 3*4 then 6*7 back to back
      Multiplicando = 16'd3;
      Multiplicador = 16'd4;
      St = 1'b1;
      tick();
      t0 = 1;
      wait_done(cyc);
      check_val("b2b_first_cycle", cyc, 33);
      check_val("b2b_first_prod", Produto, 32'd12);
      Multiplicando = 16'd6;
      Multiplicador = 16'd7;
      t0 = cyc;
      tick();
      cyc++;
      while (!Done && cyc < t0 + 45) begin
         tick();
         cyc++;
      end
      St = 1'b0;
      check_val("b2b_spacing", cyc - t0, 34);
      check_val("b2b_second_prod", Produto, 32'd42);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
